// File: rtl/run_sequencer.sv
// Test-run sequencer for a small processor: resets it, optionally preloads its
// data memory from a byte stream, starts it and times the run until done or budget exhausted.
module run_sequencer #(
   parameter int unsigned RST_CYC = 2,
   parameter logic [15:0] MAX_CYC = 16'd4000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        skip_load,
   input  logic        load_valid,
   input  logic        load_last,
   input  logic [7:0]  load_addr,
   input  logic [7:0]  load_data,
   output logic        load_ready,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        dut_reset,
   output logic        dut_req,
   input  logic        dut_done,
   output logic        busy,
   output logic        finished,
   output logic        timeout,
   output logic [15:0] cycle_count
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RST  = 3'd1;
   localparam logic [2:0] S_LOAD = 3'd2;
   localparam logic [2:0] S_REQ  = 3'd3;
   localparam logic [2:0] S_RUN  = 3'd4;
   localparam logic [2:0] S_FIN  = 3'd5;
   localparam logic [2:0] S_TO   = 3'd6;

   localparam logic [3:0] RST_LAST = 4'(RST_CYC - 1);

   logic [2:0]  state_q, state_d;
   logic [3:0]  rcnt_q, rcnt_d;
   logic [15:0] cnt_q, cnt_d;
   logic        skip_q, skip_d;
   logic        load_ready_q, dut_req_q, mem_we_q;
   logic [7:0]  mem_addr_q, mem_wdata_q;
   logic        xfer;

   assign xfer = (state_q == S_LOAD) && load_valid && load_ready_q;

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      cnt_d   = cnt_q;
      skip_d  = skip_q;
      case (state_q)
         S_IDLE, S_FIN, S_TO: begin
            if (start) begin
               state_d = S_RST;
               rcnt_d  = '0;
               cnt_d   = '0;
               skip_d  = skip_load;
            end
         end
         S_RST: begin
            if (rcnt_q == RST_LAST) state_d = skip_q ? S_REQ : S_LOAD;
            else                    rcnt_d  = rcnt_q + 4'd1;
         end
         S_LOAD: begin
            if (xfer && load_last) state_d = S_REQ;
         end
         S_REQ: state_d = S_RUN;
         S_RUN: begin
            // done wins over a budget expiring in the same cycle
            if (dut_done) state_d = S_FIN;
            else begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == MAX_CYC - 16'd1) state_d = S_TO;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rcnt_q       <= '0;
         cnt_q        <= '0;
         skip_q       <= 1'b0;
         load_ready_q <= 1'b0;
         dut_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         rcnt_q       <= rcnt_d;
         cnt_q        <= cnt_d;
         skip_q       <= skip_d;
         // registered decodes of the next state keep these glitch-free and
         // free of any path from load_valid
         load_ready_q <= (state_d == S_LOAD);
         dut_req_q    <= (state_d == S_REQ);
         mem_we_q     <= xfer;
         if (xfer) begin
            mem_addr_q  <= load_addr;
            mem_wdata_q <= load_data;
         end
      end
   end

   assign load_ready  = load_ready_q;
   assign dut_req     = dut_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign dut_reset   = reset || (state_q == S_RST);
   assign busy        = !((state_q == S_IDLE) || (state_q == S_FIN) || (state_q == S_TO));
   assign finished    = (state_q == S_FIN);
   assign timeout     = (state_q == S_TO);
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: table of runs plus preload bytes, a write scoreboard,
// and a hand-written mid-load reset sequence.
module tb_run_sequencer;

   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, skip_load = 1'b0;
   logic        load_valid = 1'b0, load_last = 1'b0, dut_done = 1'b0;
   logic [7:0]  load_addr = '0, load_data = '0;
   logic        load_ready, mem_we, dut_reset, dut_req, busy, finished, timeout;
   logic [7:0]  mem_addr, mem_wdata;
   logic [15:0] cycle_count;

   run_sequencer #(.RST_CYC(2), .MAX_CYC(16'd20)) u_dut (
      .clk(clk), .reset(reset), .start(start), .skip_load(skip_load),
      .load_valid(load_valid), .load_last(load_last), .load_addr(load_addr),
      .load_data(load_data), .load_ready(load_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dut_reset(dut_reset),
      .dut_req(dut_req), .dut_done(dut_done), .busy(busy), .finished(finished),
      .timeout(timeout), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] a; logic [7:0] d; int c; } wr_t;
   typedef struct { logic [7:0] a; logic [7:0] d; bit last; } ld_t;
   typedef struct { bit skip; bit load; int d; bit mid; bit fin; bit to; int cnt; } run_t;

   wr_t exp_q[$], obs_q[$];
   int  cyc = 0, rst_seen = 0, req_seen = 0;
   int  ntests = 0, nfail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we) obs_q.push_back('{mem_addr, mem_wdata, cyc});
      if (!reset && dut_reset) rst_seen++;
      if (dut_req) req_seen++;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_start(input bit sk);
      @(posedge clk); #1 start = 1'b1; skip_load = sk;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_finished"}, finished, 0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_dut_req"}, dut_req, 0);
      check({tag, "_load_ready"}, load_ready, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_cycle_count"}, cycle_count, 0);
      check({tag, "_dut_reset"}, dut_reset, 1);
   endtask

   initial begin
      run_t runs[6];
      ld_t  lds[3];
      wr_t  e, o;
      int   rb, qb, k, n, req_cyc, last_c;

      runs[0] = '{1, 0, 10, 0, 1, 0, 10};
      runs[1] = '{0, 1, 4,  0, 1, 0, 4};
      runs[2] = '{1, 0, -1, 0, 0, 1, 20};
      runs[3] = '{1, 0, 19, 0, 1, 0, 19};
      runs[4] = '{1, 0, 8,  1, 1, 0, 8};
      runs[5] = '{1, 0, 0,  0, 1, 0, 0};
      lds[0] = '{8'h05, 8'hA3, 0};
      lds[1] = '{8'h06, 8'h7F, 0};
      lds[2] = '{8'h07, 8'h00, 1};

      repeat (2) @(negedge clk);
      check_reset_vals("por");
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("por_release_dut_reset", dut_reset, 0);
      check("por_release_busy", busy, 0);

      for (int i = 0; i < 6; i++) begin
         rb = rst_seen; qb = req_seen; req_cyc = 0;
         do_start(runs[i].skip);
         check($sformatf("run%0d_start_busy", i), busy, 1);
         check($sformatf("run%0d_start_finished", i), finished, 0);
         check($sformatf("run%0d_start_timeout", i), timeout, 0);
         check($sformatf("run%0d_start_count", i), cycle_count, 0);
         if (runs[i].load) begin
            k = 0;
            while (!load_ready && k < 20) begin @(negedge clk); k++; end
            check($sformatf("run%0d_load_ready_up", i), load_ready, 1);
            for (int j = 0; j < 3; j++) begin
               @(posedge clk); #1 load_valid = 1'b1; load_addr = lds[j].a;
               load_data = lds[j].d; load_last = lds[j].last;
               exp_q.push_back('{lds[j].a, lds[j].d, cyc + 1});
               @(posedge clk); #1 load_valid = 1'b0; load_last = 1'b0;
            end
         end
         k = 0;
         while (!dut_req && k < 30) begin @(negedge clk); k++; end
         check($sformatf("run%0d_dut_req", i), dut_req, 1);
         req_cyc = cyc;
         if (runs[i].load) check($sformatf("run%0d_load_ready_down", i), load_ready, 0);
         n = (runs[i].d < 0) ? 21 : runs[i].d + 1;
         for (int c = 0; c < n; c++) begin
            @(posedge clk); #1 start = runs[i].mid && (c == 3);
         end
         start = 1'b0;
         if (runs[i].d >= 0) begin
            dut_done = 1'b1;
            @(posedge clk); #1 dut_done = 1'b0;
         end
         @(negedge clk);
         check($sformatf("run%0d_finished", i), finished, runs[i].fin);
         check($sformatf("run%0d_timeout", i), timeout, runs[i].to);
         check($sformatf("run%0d_count", i), cycle_count, runs[i].cnt);
         check($sformatf("run%0d_busy_end", i), busy, 0);
         check($sformatf("run%0d_rst_cycles", i), rst_seen - rb, 2);
         check($sformatf("run%0d_req_pulses", i), req_seen - qb, 1);
         if (runs[i].to) begin
            repeat (5) @(negedge clk);
            check($sformatf("run%0d_count_hold", i), cycle_count, 20);
            check($sformatf("run%0d_timeout_hold", i), timeout, 1);
         end
         check($sformatf("run%0d_nwrites", i), obs_q.size(), exp_q.size());
         last_c = 0;
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            check($sformatf("run%0d_wr_addr", i), o.a, e.a);
            check($sformatf("run%0d_wr_data", i), o.d, e.d);
            check($sformatf("run%0d_wr_cycle", i), o.c, e.c);
            last_c = o.c;
         end
         if (runs[i].load) check($sformatf("run%0d_wr_before_req", i), last_c <= req_cyc, 1);
         exp_q.delete(); obs_q.delete();
      end

      // reset while a preload byte is being offered
      do_start(0);
      k = 0;
      while (!load_ready && k < 20) begin @(negedge clk); k++; end
      check("rst_load_ready_up", load_ready, 1);
      @(posedge clk); #1 load_valid = 1'b1; load_addr = 8'h05; load_data = 8'h11;
      exp_q.push_back('{8'h05, 8'h11, cyc + 1});
      @(posedge clk); #1 load_valid = 1'b0;
      @(posedge clk); #1 load_valid = 1'b1; load_addr = 8'h22; load_data = 8'h33;
      #2 reset = 1'b1;
      #1 check_reset_vals("midload");
      repeat (3) begin
         @(negedge clk);
         check("midload_no_we", mem_we, 0);
      end
      load_valid = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("midload_release_dut_reset", dut_reset, 0);
      check("midload_release_busy", busy, 0);
      @(negedge clk);
      check("midload_nwrites", obs_q.size(), 1);
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         check("midload_wr_addr", o.a, e.a);
         check("midload_wr_data", o.d, e.d);
         check("midload_wr_cycle", o.c, e.c);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
